// File: rtl/pckthandler_vc_fsm_if.sv
// Stream bundle between the header decoder, the packet handler and the pixel unpacker.
// The master drives the aligned byte stream and header fields; the slave returns payload beats.
interface pckthandler_vc_fsm_if #(
    parameter int DATA_STREAM_WIDTH = 16
);
    localparam int BPB = DATA_STREAM_WIDTH / 8;

    logic [DATA_STREAM_WIDTH-1:0] data_stream;
    logic [23:0]                  ph_stream;
    logic                         ph_select;
    logic                         valid_stream;
    logic                         ecc_error;

    logic [DATA_STREAM_WIDTH-1:0] out_stream;
    logic [BPB-1:0]               out_byte_en;
    logic                         frame_valid;
    logic                         last_packet;

    modport master (
        output data_stream, ph_stream, ph_select, valid_stream, ecc_error,
        input  out_stream, out_byte_en, frame_valid, last_packet
    );

    modport slave (
        input  data_stream, ph_stream, ph_select, valid_stream, ecc_error,
        output out_stream, out_byte_en, frame_valid, last_packet
    );
endinterface

// File: rtl/pckthandler_vc_fsm.sv
// CSI-2 packet handler: filters packets by virtual channel and data type, tracks frame/line
// state and emits long-packet payload as width-configurable beats with byte enables.
module pckthandler_vc_fsm #(
    parameter int DATA_STREAM_WIDTH = 16,
    parameter int PH_STREAM_WIDTH   = 24,
    parameter int LINE_COUNT_WIDTH  = 16
) (
    input  logic                        rxbyteclkhs,
    input  logic                        reset,
    pckthandler_vc_fsm_if.slave         bus,
    input  logic [1:0]                  vc_select,
    input  logic [5:0]                  dt_select,
    input  logic [LINE_COUNT_WIDTH-1:0] lines_per_frame,
    output logic                        frame_active,
    output logic [LINE_COUNT_WIDTH-1:0] line_count,
    output logic [15:0]                 frame_number,
    output logic                        err_ecc,
    output logic                        err_frame,
    output logic                        err_trunc
);
    localparam int BPB = DATA_STREAM_WIDTH / 8;
    localparam int LCW = LINE_COUNT_WIDTH;
    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;

    typedef enum logic [1:0] {
        PH_DECODE = 2'd0,
        REC_DATA  = 2'd1,
        WAIT_EOT  = 2'd2
    } state_e;

    state_e                       state_q;
    logic [15:0]                  packet_size_q;
    logic [16:0]                  byte_count_q;
    logic                         last_line_q;
    logic [DATA_STREAM_WIDTH-1:0] out_stream_q;
    logic [BPB-1:0]               out_byte_en_q;
    logic                         frame_valid_q;
    logic                         last_packet_q;
    logic                         frame_active_q;
    logic [LCW-1:0]               line_count_q;
    logic [15:0]                  frame_number_q;
    logic                         err_ecc_q;
    logic                         err_frame_q;
    logic                         err_trunc_q;

    logic [PH_STREAM_WIDTH-1:0]   ph_s;
    logic [15:0]                  wc_s;
    logic [1:0]                   vc_s;
    logic [5:0]                   dt_s;
    logic                         hdr_ok_s;
    logic                         lpf_set_s;
    logic [LCW-1:0]               line_count_d;
    logic [16:0]                  byte_count_d;
    logic [16:0]                  remaining_s;
    logic                         last_beat_s;
    logic [BPB-1:0]               last_en_s;

    assign ph_s         = bus.ph_stream;
    assign wc_s         = ph_s[23:8];
    assign vc_s         = ph_s[7:6];
    assign dt_s         = ph_s[5:0];
    assign hdr_ok_s     = bus.valid_stream & bus.ph_select & ~bus.ecc_error & (vc_s == vc_select);
    assign lpf_set_s    = (lines_per_frame != {LCW{1'b0}});
    assign line_count_d = line_count_q + {{(LCW-1){1'b0}}, 1'b1};
    assign byte_count_d = byte_count_q + 17'(BPB);
    // Bytes still owed before this beat; 17 bits so a 0xFFFF word count never wraps.
    assign remaining_s  = {1'b0, packet_size_q} - byte_count_q;
    assign last_beat_s  = (remaining_s <= 17'(BPB));

    // Byte-enable mask for a final beat carrying fewer than BPB bytes.
    always_comb begin
        last_en_s = {BPB{1'b0}};
        for (int i = 0; i < BPB; i++) begin
            last_en_s[i] = (17'(i) < remaining_s);
        end
    end

    // Packet FSM with registered outputs; beat fields and error pulses default low each cycle.
    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            state_q        <= PH_DECODE;
            packet_size_q  <= 16'd0;
            byte_count_q   <= 17'd0;
            last_line_q    <= 1'b0;
            out_stream_q   <= {DATA_STREAM_WIDTH{1'b0}};
            out_byte_en_q  <= {BPB{1'b0}};
            frame_valid_q  <= 1'b0;
            last_packet_q  <= 1'b0;
            frame_active_q <= 1'b0;
            line_count_q   <= {LCW{1'b0}};
            frame_number_q <= 16'd0;
            err_ecc_q      <= 1'b0;
            err_frame_q    <= 1'b0;
            err_trunc_q    <= 1'b0;
        end else begin
            out_stream_q  <= {DATA_STREAM_WIDTH{1'b0}};
            out_byte_en_q <= {BPB{1'b0}};
            frame_valid_q <= 1'b0;
            last_packet_q <= 1'b0;
            err_ecc_q     <= 1'b0;
            err_frame_q   <= 1'b0;
            err_trunc_q   <= 1'b0;
            case (state_q)
                PH_DECODE: begin
                    if (bus.valid_stream) begin
                        state_q <= WAIT_EOT;
                        if (bus.ph_select & bus.ecc_error) begin
                            err_ecc_q <= 1'b1;
                        end else if (hdr_ok_s && dt_s == DT_FS) begin
                            err_frame_q    <= frame_active_q;
                            frame_active_q <= 1'b1;
                            line_count_q   <= {LCW{1'b0}};
                            frame_number_q <= wc_s;
                        end else if (hdr_ok_s && dt_s == DT_FE) begin
                            err_frame_q    <= lpf_set_s && (line_count_q != lines_per_frame);
                            frame_active_q <= 1'b0;
                            line_count_q   <= {LCW{1'b0}};
                        end else if (hdr_ok_s && dt_s == dt_select && frame_active_q) begin
                            if (lpf_set_s && line_count_q == lines_per_frame) begin
                                err_frame_q <= 1'b1;
                            end else begin
                                packet_size_q <= wc_s;
                                byte_count_q  <= 17'd0;
                                line_count_q  <= line_count_d;
                                last_line_q   <= (line_count_d == lines_per_frame);
                                if (wc_s != 16'd0) begin
                                    state_q <= REC_DATA;
                                end else begin
                                    state_q <= WAIT_EOT;
                                end
                            end
                        end else begin
                            state_q <= WAIT_EOT;
                        end
                    end else begin
                        state_q <= PH_DECODE;
                    end
                end
                REC_DATA: begin
                    if (bus.valid_stream) begin
                        out_stream_q  <= bus.data_stream;
                        frame_valid_q <= 1'b1;
                        byte_count_q  <= byte_count_d;
                        if (last_beat_s) begin
                            out_byte_en_q <= last_en_s;
                            last_packet_q <= last_line_q;
                            state_q       <= WAIT_EOT;
                        end else begin
                            out_byte_en_q <= {BPB{1'b1}};
                        end
                    end else begin
                        // Truncated packet: the line was already counted at its header.
                        err_trunc_q <= 1'b1;
                        state_q     <= PH_DECODE;
                    end
                end
                WAIT_EOT: begin
                    if (bus.valid_stream) begin
                        state_q <= WAIT_EOT;
                    end else begin
                        state_q <= PH_DECODE;
                    end
                end
                default: begin
                    state_q <= PH_DECODE;
                end
            endcase
        end
    end

    assign bus.out_stream  = out_stream_q;
    assign bus.out_byte_en = out_byte_en_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.last_packet = last_packet_q;
    assign frame_active    = frame_active_q;
    assign line_count      = line_count_q;
    assign frame_number    = frame_number_q;
    assign err_ecc         = err_ecc_q;
    assign err_frame       = err_frame_q;
    assign err_trunc       = err_trunc_q;
endmodule
